rotor_stepper: RTL and testbench

ROTOR_STEPPER -- requirements
Module: rotor_stepper

---
 rtl/rotor_stepper.sv | 97 +++++++++
 tb/tb_rotor_stepper.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rotor_stepper.sv
// Three-rotor stepping controller with double-step; step accepted at edge E0 shows new positions after E1.
// Positions hold in PRESENT until pos_ready; step_valid outside IDLE is dropped, never queued.
module rotor_stepper #(
    parameter int NOTCH_R = 21,
    parameter int NOTCH_M = 4,
    parameter int NOTCH_L = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [4:0]  load_pos_l,
    input  logic [4:0]  load_pos_m,
    input  logic [4:0]  load_pos_r,
    input  logic        step_valid,
    output logic        step_ready,
    output logic [4:0]  pos_l,
    output logic [4:0]  pos_m,
    output logic [4:0]  pos_r,
    output logic        pos_valid,
    input  logic        pos_ready,
    output logic [15:0] char_count,
    output logic        load_err
);

    // The left notch is reserved (left rotor never carries) but is still range-checked.
    if (NOTCH_R > 25 || NOTCH_M > 25 || NOTCH_L > 25) begin : g_bad_notch
        $error("rotor_stepper: notch parameters must be in 0..25");
    end

    typedef enum logic [1:0] {IDLE, STEP, PRESENT} state_t;
    state_t state;

    localparam logic [4:0] NR = 5'(NOTCH_R);
    localparam logic [4:0] NM = 5'(NOTCH_M);

    function automatic logic [4:0] inc26(input logic [4:0] p);
        return (p == 5'd25) ? 5'd0 : p + 5'd1;
    endfunction

    logic load_ok;
    logic turn_m;
    logic turn_l;

    assign load_ok    = (load_pos_l <= 5'd25) && (load_pos_m <= 5'd25) && (load_pos_r <= 5'd25);
    assign turn_l     = (pos_m == NM);
    assign turn_m     = (pos_r == NR) || turn_l;
    assign step_ready = rst_n && (state == IDLE) && !load_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pos_l      <= 5'd0;
            pos_m      <= 5'd0;
            pos_r      <= 5'd0;
            pos_valid  <= 1'b0;
            char_count <= 16'd0;
            load_err   <= 1'b0;
        end else begin
            load_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        if (load_ok) begin
                            pos_l <= load_pos_l;
                            pos_m <= load_pos_m;
                            pos_r <= load_pos_r;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end else if (step_valid) begin
                        state <= STEP;
                    end
                end
                STEP: begin
                    // Decisions use pre-step positions, giving the middle-rotor double step.
                    pos_r      <= inc26(pos_r);
                    pos_m      <= turn_m ? inc26(pos_m) : pos_m;
                    pos_l      <= turn_l ? inc26(pos_l) : pos_l;
                    char_count <= char_count + 16'd1;
                    pos_valid  <= 1'b1;
                    state      <= PRESENT;
                end
                PRESENT: begin
                    if (pos_ready) begin
                        pos_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    pos_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotor_stepper.sv
// Table-driven directed checks plus randomized load/step traffic against an arithmetic rotor model.
module tb_rotor_stepper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic [4:0]  load_pos_l, load_pos_m, load_pos_r;
    logic        step_valid;
    logic        step_ready;
    logic [4:0]  pos_l, pos_m, pos_r;
    logic        pos_valid;
    logic        pos_ready;
    logic [15:0] char_count;
    logic        load_err;

    rotor_stepper #(.NOTCH_R(21), .NOTCH_M(4), .NOTCH_L(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_pos_l(load_pos_l), .load_pos_m(load_pos_m), .load_pos_r(load_pos_r),
        .step_valid(step_valid), .step_ready(step_ready),
        .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r),
        .pos_valid(pos_valid), .pos_ready(pos_ready),
        .char_count(char_count), .load_err(load_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: rotor positions as plain integers 0..25
    int ml, mm, mr, mcount;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_pos(input string name);
        chk({name, ".l"}, int'(pos_l), ml);
        chk({name, ".m"}, int'(pos_m), mm);
        chk({name, ".r"}, int'(pos_r), mr);
        chk({name, ".count"}, int'(char_count), mcount);
    endtask

    task automatic model_step();
        int nl, nm, nr;
        nr = (mr + 1) % 26;
        nm = (mr == 21 || mm == 4) ? (mm + 1) % 26 : mm;
        nl = (mm == 4) ? (ml + 1) % 26 : ml;
        ml = nl; mm = nm; mr = nr;
        mcount = (mcount + 1) % 65536;
    endtask

    task automatic do_load(input int l, input int m, input int r);
        bit ok;
        ok = (l <= 25) && (m <= 25) && (r <= 25);
        @(negedge clk);
        load_valid = 1'b1;
        load_pos_l = 5'(l); load_pos_m = 5'(m); load_pos_r = 5'(r);
        #1;
        chk("load_blocks_step_ready", int'(step_ready), 0);
        @(negedge clk);
        load_valid = 1'b0;
        if (ok) begin
            ml = l; mm = m; mr = r;
        end
        chk("load_err", int'(load_err), ok ? 0 : 1);
        chk_pos("after_load");
        @(negedge clk);
        chk("load_err_clear", int'(load_err), 0);
    endtask

    task automatic do_step();
        @(negedge clk);
        step_valid = 1'b1;
        #1;
        chk("step_ready_idle", int'(step_ready), 1);
        @(negedge clk);
        step_valid = 1'b0;
        chk("pos_valid_in_step", int'(pos_valid), 0);
        @(negedge clk);
        model_step();
        chk("pos_valid_present", int'(pos_valid), 1);
        chk_pos("after_step");
        pos_ready = 1'b1;
        @(negedge clk);
        pos_ready = 1'b0;
        chk("pos_valid_back_idle", int'(pos_valid), 0);
    endtask

    typedef struct {
        int l, m, r;
        int nsteps;
        int el, em, er;
    } vec_t;

    vec_t tbl[$];

    initial begin
        rst_n = 1'b0;
        load_valid = 1'b0; load_pos_l = '0; load_pos_m = '0; load_pos_r = '0;
        step_valid = 1'b1;
        pos_ready = 1'b0;
        ml = 0; mm = 0; mr = 0; mcount = 0;

        // Reset state, with step_valid asserted to show step_ready stays low
        repeat (2) @(negedge clk);
        chk("reset_step_ready", int'(step_ready), 0);
        chk("reset_pos_valid", int'(pos_valid), 0);
        chk("reset_load_err", int'(load_err), 0);
        chk_pos("reset");
        step_valid = 1'b0;
        rst_n = 1'b1;

        do_step();  // (0,0,0) -> (0,0,1), count 1

        tbl.push_back('{0, 0, 21, 1, 0, 1, 22});
        tbl.push_back('{0, 0, 21, 2, 0, 1, 23});
        tbl.push_back('{0, 3, 21, 1, 0, 4, 22});
        tbl.push_back('{0, 3, 21, 2, 1, 5, 23});
        tbl.push_back('{25, 4, 25, 1, 0, 5, 0});
        tbl.push_back('{7, 7, 7, 1, 7, 7, 8});
        tbl.push_back('{5, 4, 20, 2, 6, 6, 22});
        tbl.push_back('{24, 25, 21, 1, 24, 0, 22});
        foreach (tbl[i]) begin
            do_load(tbl[i].l, tbl[i].m, tbl[i].r);
            for (int s = 0; s < tbl[i].nsteps; s++) do_step();
            chk($sformatf("tbl%0d.l", i), int'(pos_l), tbl[i].el);
            chk($sformatf("tbl%0d.m", i), int'(pos_m), tbl[i].em);
            chk($sformatf("tbl%0d.r", i), int'(pos_r), tbl[i].er);
        end

        // Backpressure: hold in PRESENT with step_valid high
        @(negedge clk);
        step_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_step();
        for (int c = 0; c < 10; c++) begin
            chk("bp_pos_valid", int'(pos_valid), 1);
            chk("bp_step_ready", int'(step_ready), 0);
            chk_pos("bp_hold");
            @(negedge clk);
        end
        step_valid = 1'b0;
        pos_ready = 1'b1;
        @(negedge clk);
        pos_ready = 1'b0;
        @(negedge clk);
        chk("bp_no_extra_step", int'(pos_valid), 0);
        chk_pos("bp_release");

        // Rejected load
        do_load(3, 26, 0);

        // Load and step together: load wins
        @(negedge clk);
        load_valid = 1'b1; step_valid = 1'b1;
        load_pos_l = 5'd9; load_pos_m = 5'd10; load_pos_r = 5'd11;
        #1;
        chk("both_step_ready", int'(step_ready), 0);
        @(negedge clk);
        load_valid = 1'b0; step_valid = 1'b0;
        ml = 9; mm = 10; mr = 11;
        chk_pos("both_load");
        @(negedge clk);
        chk("both_no_step", int'(pos_valid), 0);
        chk_pos("both_idle");

        // Load ignored while not idle
        @(negedge clk);
        step_valid = 1'b1;
        @(negedge clk);
        step_valid = 1'b0;
        load_valid = 1'b1; load_pos_l = 5'd1; load_pos_m = 5'd30; load_pos_r = 5'd2;
        @(negedge clk);
        model_step();
        chk("busy_load_no_err", int'(load_err), 0);
        chk_pos("busy_load_ignored");
        @(negedge clk);
        chk("busy_load_no_err2", int'(load_err), 0);
        chk_pos("busy_load_ignored2");
        load_valid = 1'b0;
        pos_ready = 1'b1;
        @(negedge clk);
        pos_ready = 1'b0;

        // Reset during STEP aborts the update
        @(negedge clk);
        step_valid = 1'b1;
        @(negedge clk);
        step_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ml = 0; mm = 0; mr = 0; mcount = 0;
        chk("abort_pos_valid", int'(pos_valid), 0);
        chk_pos("abort");
        @(negedge clk);
        chk("abort_stays_idle", int'(pos_valid), 0);

        // Randomized traffic
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 3))
                0: do_load($urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(0, 25));
                1: do_load($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
                default: do_step();
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
